alarm_time_bank: RTL and testbench



---
 rtl/alarm_time_bank.sv | 223 ++++++++++++++++++++++
 tb/tb_alarm_time_bank.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_time_bank.sv
// Bank of NUM_ALARMS editable alarm slots with auto-repeat buttons, a registered
// 12-hour BCD view of the selected slot and a fire pulse. Optional macro: ALARM_MODE_24H_EN.
module alarm_time_bank #(
  parameter int NUM_ALARMS       = 4,
  parameter int START_MINUTES    = 0,
  parameter int START_HOURS      = 0,
  parameter int REPEAT_DELAY_CYC = 2500000,
  parameter int REPEAT_RATE_CYC  = 500000,
  localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  i_Clk_5MHz,
  input  logic                  i_Reset,
  input  logic [SEL_W-1:0]      i_Sel,
  input  logic                  i_Minutes_Inc,
  input  logic                  i_Hours_Inc,
  input  logic                  i_Enable_Toggle,
  input  logic [5:0]            i_Cur_Minutes,
  input  logic [4:0]            i_Cur_Hours,
`ifdef ALARM_MODE_24H_EN
  input  logic                  i_Mode_24h,
`endif
  output logic [15:0]           o_Alarm_Time,
  output logic                  o_PM,
  output logic                  o_Enabled,
  output logic [NUM_ALARMS-1:0] o_Match,
  output logic                  o_Fire,
  output logic [SEL_W-1:0]      o_Fire_Id
);

  localparam int MAX_CYC = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(REPEAT_DELAY_CYC);
  localparam logic [CNT_W-1:0] RATE_C  = CNT_W'(REPEAT_RATE_CYC);
  localparam logic [SEL_W:0]   NUM_C   = (SEL_W + 1)'(NUM_ALARMS);
  localparam logic [5:0]       START_M = 6'(START_MINUTES);
  localparam logic [4:0]       START_H = 5'(START_HOURS);

  typedef enum logic [2:0] {IDLE, PRESS, HOLD, REPEAT, LOCK} BtnState;

  function automatic logic [7:0] toBcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  // Returns {pm, hour tens, hour ones, minute tens, minute ones}.
  function automatic logic [16:0] toDisplay(input logic [4:0] hours, input logic [5:0] minutes,
                                            input logic mode24);
    logic [4:0] dispHours;
    logic       pm;
    dispHours = hours;
    pm        = 1'b0;
    if (!mode24) begin
      pm = (hours >= 5'd12);
      if (hours == 5'd0)
        dispHours = 5'd12;
      else if (hours > 5'd12)
        dispHours = hours - 5'd12;
    end
    return {pm, toBcd({1'b0, dispHours}), toBcd(minutes)};
  endfunction

  logic [5:0]            r_Min [NUM_ALARMS];
  logic [4:0]            r_Hour [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] r_En;
  BtnState               r_State [2];
  BtnState               w_NextState [2];
  logic [CNT_W-1:0]      r_Cnt [2];
  logic [CNT_W-1:0]      w_NextCnt [2];
  logic [CNT_W-1:0]      w_CntPlus [2];
  logic [1:0]            w_Btn;
  logic [1:0]            w_Inc;
  logic [SEL_W-1:0]      r_PrevSel;
  logic [10:0]           r_PrevTime;
  logic [15:0]           r_AlarmTime;
  logic                  r_PM;
  logic                  r_Enabled;
  logic [NUM_ALARMS-1:0] r_Match;
  logic                  r_Fire;
  logic [SEL_W-1:0]      r_FireId;
  logic [NUM_ALARMS-1:0] w_Hit;
  logic [SEL_W-1:0]      w_FireIdx;
  logic [SEL_W-1:0]      w_DispIdx;
  logic [10:0]           w_CurTime;
  logic                  w_SelValid;
  logic                  w_SelChanged;
  logic                  w_TimeChanged;
  logic                  w_Mode24;

  assign w_Btn         = {i_Hours_Inc, i_Minutes_Inc};
  assign w_SelValid    = ({1'b0, i_Sel} < NUM_C);
  assign w_SelChanged  = (i_Sel != r_PrevSel);
  assign w_DispIdx     = w_SelValid ? i_Sel : '0;
  assign w_CurTime     = {i_Cur_Hours, i_Cur_Minutes};
  assign w_TimeChanged = (w_CurTime != r_PrevTime);
`ifdef ALARM_MODE_24H_EN
  assign w_Mode24 = i_Mode_24h;
`else
  assign w_Mode24 = 1'b0;
`endif

  // Index 0 is the minute button, index 1 the hour button; the first repeat
  // fires on the HOLD->REPEAT transition, later ones every REPEAT_RATE_CYC.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_NextState[b] = r_State[b];
      w_NextCnt[b]   = r_Cnt[b];
      w_CntPlus[b]   = r_Cnt[b] + CNT_W'(1);
      w_Inc[b]       = 1'b0;
      if (!w_Btn[b]) begin
        w_NextState[b] = IDLE;
        w_NextCnt[b]   = '0;
      end else begin
        case (r_State[b])
          IDLE: w_NextState[b] = PRESS;
          PRESS: begin
            if (w_SelChanged) begin
              w_NextState[b] = LOCK;
            end else begin
              w_Inc[b]       = 1'b1;
              w_NextState[b] = HOLD;
              w_NextCnt[b]   = '0;
            end
          end
          HOLD: begin
            if (w_SelChanged) begin
              w_NextState[b] = LOCK;
            end else if (w_CntPlus[b] == DELAY_C) begin
              w_Inc[b]       = 1'b1;
              w_NextState[b] = REPEAT;
              w_NextCnt[b]   = '0;
            end else begin
              w_NextCnt[b] = w_CntPlus[b];
            end
          end
          REPEAT: begin
            if (w_SelChanged) begin
              w_NextState[b] = LOCK;
            end else if (w_CntPlus[b] == RATE_C) begin
              w_Inc[b]     = 1'b1;
              w_NextCnt[b] = '0;
            end else begin
              w_NextCnt[b] = w_CntPlus[b];
            end
          end
          LOCK:    w_NextState[b] = LOCK;
          default: w_NextState[b] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_Clk_5MHz) begin
    for (int b = 0; b < 2; b++) begin
      if (i_Reset) begin
        r_State[b] <= IDLE;
        r_Cnt[b]   <= '0;
      end else begin
        r_State[b] <= w_NextState[b];
        r_Cnt[b]   <= w_NextCnt[b];
      end
    end
  end

  always_ff @(posedge i_Clk_5MHz) begin
    if (i_Reset) begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
        r_Min[k]  <= START_M;
        r_Hour[k] <= START_H;
      end
      r_En <= '0;
    end else if (w_SelValid) begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
        if (i_Sel == SEL_W'(k)) begin
          if (w_Inc[0])
            r_Min[k] <= (r_Min[k] == 6'd59) ? 6'd0 : r_Min[k] + 6'd1;
          if (w_Inc[1])
            r_Hour[k] <= (r_Hour[k] == 5'd23) ? 5'd0 : r_Hour[k] + 5'd1;
          if (i_Enable_Toggle)
            r_En[k] <= ~r_En[k];
        end
      end
    end
  end

  always_comb begin
    w_Hit     = '0;
    w_FireIdx = '0;
    for (int k = 0; k < NUM_ALARMS; k++)
      w_Hit[k] = r_En[k] && (r_Min[k] == i_Cur_Minutes) && (r_Hour[k] == i_Cur_Hours);
    for (int k = NUM_ALARMS - 1; k >= 0; k--)
      if (w_Hit[k])
        w_FireIdx = SEL_W'(k);
  end

  // Firing is keyed to a change of the running time, so edits never fire.
  always_ff @(posedge i_Clk_5MHz) begin
    if (i_Reset) begin
      {r_PM, r_AlarmTime} <= toDisplay(START_H, START_M, 1'b0);
      r_Enabled  <= 1'b0;
      r_Match    <= '0;
      r_Fire     <= 1'b0;
      r_FireId   <= '0;
      r_PrevTime <= '0;
      r_PrevSel  <= '0;
    end else begin
      {r_PM, r_AlarmTime} <= toDisplay(r_Hour[w_DispIdx], r_Min[w_DispIdx], w_Mode24);
      r_Enabled  <= r_En[w_DispIdx];
      r_Match    <= w_Hit;
      r_Fire     <= w_TimeChanged && (|w_Hit);
      if (w_TimeChanged && (|w_Hit))
        r_FireId <= w_FireIdx;
      r_PrevTime <= w_CurTime;
      r_PrevSel  <= i_Sel;
    end
  end

  assign o_Alarm_Time = r_AlarmTime;
  assign o_PM         = r_PM;
  assign o_Enabled    = r_Enabled;
  assign o_Match      = r_Match;
  assign o_Fire       = r_Fire;
  assign o_Fire_Id    = r_FireId;

endmodule

// File: tb/tb_alarm_time_bank.sv
// Self-checking bench for alarm_time_bank: directed plan steps plus randomized edits and
// time sweeps against an arithmetic slot model. Exercises ALARM_MODE_24H_EN when defined.
module tb_alarm_time_bank;

  localparam int NUM   = 5;
  localparam int SELW  = 3;
  localparam int DELAY = 10;
  localparam int RATE  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [SELW-1:0] sel;
  logic            minInc;
  logic            hrInc;
  logic            enTog;
  logic [5:0]      curMinutes;
  logic [4:0]      curHours;
  logic [15:0]     alarmTime;
  logic            pm;
  logic            enabled;
  logic [NUM-1:0]  match;
  logic            fire;
  logic [SELW-1:0] fireId;
`ifdef ALARM_MODE_24H_EN
  logic            mode24h;
`endif

  int checks = 0;
  int failures = 0;
  int fireCount = 0;
  int mdlMin [NUM];
  int mdlHr [NUM];
  bit mdlEn [NUM];
  int mdlFireId;
  bit mdlMode24;
  int curH;
  int curM;

  alarm_time_bank #(
    .NUM_ALARMS(NUM),
    .START_MINUTES(0),
    .START_HOURS(0),
    .REPEAT_DELAY_CYC(DELAY),
    .REPEAT_RATE_CYC(RATE)
  ) dut (
    .i_Clk_5MHz(clk),
    .i_Reset(rst),
    .i_Sel(sel),
    .i_Minutes_Inc(minInc),
    .i_Hours_Inc(hrInc),
    .i_Enable_Toggle(enTog),
    .i_Cur_Minutes(curMinutes),
    .i_Cur_Hours(curHours),
`ifdef ALARM_MODE_24H_EN
    .i_Mode_24h(mode24h),
`endif
    .o_Alarm_Time(alarmTime),
    .o_PM(pm),
    .o_Enabled(enabled),
    .o_Match(match),
    .o_Fire(fire),
    .o_Fire_Id(fireId)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (fire === 1'b1)
      fireCount++;

  initial begin
    #2000000;
    failures++;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit selValid(input int s);
    return s < NUM;
  endfunction

  // A hold of n sampled cycles: one press, the first repeat DELAY cycles later, then one per RATE.
  function automatic int holdIncrements(input int n);
    if (n < 2) return 0;
    if (n < DELAY + 2) return 1;
    return 2 + (n - 2 - DELAY) / RATE;
  endfunction

  function automatic int holdForDelta(input int d);
    if (d == 1) return 2;
    return DELAY + 2 + RATE * (d - 2);
  endfunction

  function automatic logic [16:0] expDisp(input int h, input int m, input bit mode24);
    int hh;
    bit isPm;
    if (mode24) begin
      hh   = h;
      isPm = 1'b0;
    end else begin
      hh   = (h % 12 == 0) ? 12 : h % 12;
      isPm = (h >= 12);
    end
    return {isPm, 4'(hh / 10), 4'(hh % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic modelReset();
    for (int k = 0; k < NUM; k++) begin
      mdlMin[k] = 0;
      mdlHr[k]  = 0;
      mdlEn[k]  = 1'b0;
    end
    mdlFireId = 0;
  endtask

  task automatic applyStimulus(input logic minB, input logic hrB, input int n);
    int k;
    minInc = minB;
    hrInc  = hrB;
    repeat (n) tick();
    minInc = 1'b0;
    hrInc  = 1'b0;
    repeat (2) tick();
    k = holdIncrements(n);
    if (selValid(int'(sel))) begin
      if (minB) mdlMin[sel] = (mdlMin[sel] + k) % 60;
      if (hrB)  mdlHr[sel]  = (mdlHr[sel] + k) % 24;
    end
  endtask

  task automatic toggleEnable();
    enTog = 1'b1;
    tick();
    enTog = 1'b0;
    repeat (2) tick();
    if (selValid(int'(sel)))
      mdlEn[sel] = !mdlEn[sel];
  endtask

  task automatic selectSlot(input int s);
    sel = SELW'(s);
    repeat (2) tick();
  endtask

  task automatic setSlot(input int s, input int h, input int m);
    int d;
    selectSlot(s);
    d = (h - mdlHr[s] + 24) % 24;
    if (d > 0) applyStimulus(1'b0, 1'b1, holdForDelta(d));
    d = (m - mdlMin[s] + 60) % 60;
    if (d > 0) applyStimulus(1'b1, 1'b0, holdForDelta(d));
  endtask

  task automatic checkDisplay(input string tag);
    int idx;
    logic [16:0] e;
    idx = selValid(int'(sel)) ? int'(sel) : 0;
    e = expDisp(mdlHr[idx], mdlMin[idx], mdlMode24);
    checkOutput({tag, ".time"}, alarmTime, e[15:0]);
    checkOutput({tag, ".pm"}, pm, e[16]);
    checkOutput({tag, ".enabled"}, enabled, mdlEn[idx]);
  endtask

  task automatic checkTime(input string tag, input int h, input int m);
    bit changed;
    bit found;
    logic [NUM-1:0] expMatch;
    changed    = (h != curH) || (m != curM);
    curH       = h;
    curM       = m;
    curHours   = 5'(h);
    curMinutes = 6'(m);
    tick();
    expMatch = '0;
    found    = 1'b0;
    for (int k = 0; k < NUM; k++) begin
      expMatch[k] = mdlEn[k] && (mdlHr[k] == h) && (mdlMin[k] == m);
      if (changed && expMatch[k] && !found) begin
        mdlFireId = k;
        found     = 1'b1;
      end
    end
    checkOutput({tag, ".match"}, match, expMatch);
    checkOutput({tag, ".fire"}, fire, found);
    checkOutput({tag, ".fireId"}, fireId, mdlFireId);
    tick();
    checkOutput({tag, ".fireLow"}, fire, 1'b0);
  endtask

  initial begin
    int fc0;
    int n;
    int s;
    rst        = 1'b1;
    sel        = '0;
    minInc     = 1'b0;
    hrInc      = 1'b0;
    enTog      = 1'b0;
    curHours   = '0;
    curMinutes = '0;
    curH       = 0;
    curM       = 0;
    mdlMode24  = 1'b0;
`ifdef ALARM_MODE_24H_EN
    mode24h    = 1'b0;
`endif
    modelReset();
    repeat (2) tick();
    rst = 1'b0;
    $display("[TB] reset state");
    checkOutput("reset.time", alarmTime, 16'h1200);
    checkOutput("reset.pm", pm, 1'b0);
    checkOutput("reset.enabled", enabled, 1'b0);
    checkOutput("reset.match", match, '0);
    checkOutput("reset.fire", fire, 1'b0);
    checkOutput("reset.fireId", fireId, '0);

    $display("[TB] auto-repeat hold");
    applyStimulus(1'b1, 1'b0, 23);
    checkOutput("hold23.time", alarmTime, 16'h1204);
    checkDisplay("hold23");

    $display("[TB] wrap 23:59");
    setSlot(1, 23, 59);
    checkDisplay("slot1.2359");
    applyStimulus(1'b1, 1'b1, 2);
    checkOutput("wrap.time", alarmTime, 16'h1200);
    checkOutput("wrap.pm", pm, 1'b0);
    selectSlot(0);
    checkOutput("wrap.slot0", alarmTime, 16'h1204);

    $display("[TB] noon and 13h");
    setSlot(2, 12, 0);
    checkOutput("noon.time", alarmTime, 16'h1200);
    checkOutput("noon.pm", pm, 1'b1);
    applyStimulus(1'b0, 1'b1, 2);
    checkOutput("13h.time", alarmTime, 16'h0100);
    checkOutput("13h.pm", pm, 1'b1);

    $display("[TB] select change locks held button");
    selectSlot(4);
    minInc = 1'b1;
    repeat (12) tick();
    sel = 3'd1;
    repeat (20) tick();
    minInc = 1'b0;
    repeat (2) tick();
    mdlMin[4] = (mdlMin[4] + holdIncrements(12)) % 60;
    checkDisplay("lock.slot1");
    selectSlot(4);
    checkDisplay("lock.slot4");

    $display("[TB] out-of-range select");
    selectSlot(6);
    checkDisplay("oor.before");
    applyStimulus(1'b1, 1'b1, 15);
    toggleEnable();
    checkDisplay("oor.after");
    selectSlot(0);
    checkDisplay("oor.slot0");

    $display("[TB] toggle with increment");
    selectSlot(2);
    minInc = 1'b1;
    tick();
    enTog = 1'b1;
    tick();
    enTog  = 1'b0;
    minInc = 1'b0;
    repeat (2) tick();
    mdlMin[2] = (mdlMin[2] + holdIncrements(2)) % 60;
    mdlEn[2]  = 1'b1;
    checkDisplay("togInc");

    $display("[TB] fire");
    checkTime("t0729", 7, 29);
    setSlot(1, 7, 30);
    toggleEnable();
    setSlot(3, 7, 30);
    toggleEnable();
    checkOutput("noEarlyFire", fireCount, 0);
    checkTime("t0730", 7, 30);
    checkOutput("t0730.id", fireId, 3'd1);
    checkOutput("t0730.matchLit", match, 5'b01010);
    checkOutput("t0730.count", fireCount, 1);
    fc0 = fireCount;
    setSlot(0, 7, 30);
    toggleEnable();
    repeat (3) tick();
    checkOutput("editNoFire", fireCount, fc0);
    checkOutput("editMatch", match, 5'b01011);

    $display("[TB] reset mid-hold");
    selectSlot(0);
    minInc = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelReset();
    repeat (2) tick();
    minInc = 1'b0;
    repeat (2) tick();
    mdlMin[0] = holdIncrements(2);
    checkDisplay("rstHold");
    checkOutput("rstHold.match", match, '0);
    checkOutput("rstHold.fireId", fireId, '0);

    $display("[TB] random edits");
    for (int it = 0; it < 25; it++) begin
      selectSlot($urandom_range(0, NUM - 1));
      n = $urandom_range(2, 40);
      case ($urandom_range(0, 3))
        0: applyStimulus(1'b1, 1'b0, n);
        1: applyStimulus(1'b0, 1'b1, n);
        2: applyStimulus(1'b1, 1'b1, n);
        default: toggleEnable();
      endcase
      checkDisplay("rnd.edit");
    end

    $display("[TB] random times");
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        s = $urandom_range(0, NUM - 1);
        checkTime("rnd.slotTime", mdlHr[s], mdlMin[s]);
      end else begin
        checkTime("rnd.anyTime", $urandom_range(0, 23), $urandom_range(0, 59));
      end
    end

`ifdef ALARM_MODE_24H_EN
    $display("[TB] 24-hour mode");
    setSlot(0, 18, 5);
    mode24h   = 1'b1;
    mdlMode24 = 1'b1;
    repeat (2) tick();
    checkOutput("m24.time", alarmTime, 16'h1805);
    checkOutput("m24.pm", pm, 1'b0);
    checkDisplay("m24");
    mode24h   = 1'b0;
    mdlMode24 = 1'b0;
    repeat (2) tick();
    checkOutput("m12.time", alarmTime, 16'h0605);
    checkOutput("m12.pm", pm, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
